// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the Hack data-memory map.
// Optional scan-out engine is built when HACK_MEM_SCAN_EN is defined.
package hack_mem_pkg;

   localparam int unsigned DEF_DATA_W     = 16;
   localparam int unsigned DEF_ADDR_W     = 15;
   localparam int unsigned DEF_RAM_AW     = 14;
   localparam int unsigned DEF_SCR_AW     = 13;
   localparam int unsigned DEF_LINE_WORDS = 32;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_SCR,
      REG_KBD,
      REG_NONE
   } region_e;

   typedef enum logic {
      SCAN_IDLE,
      SCAN_RUN
   } scan_state_e;

   // KBD sits directly after RAM and screen.
   function automatic int unsigned kbd_addr(input int unsigned ram_aw, input int unsigned scr_aw);
      return (32'd1 << ram_aw) + (32'd1 << scr_aw);
   endfunction

endpackage

// File: rtl/hack_mem_map_if.sv
// CPU data port, keyboard front end and screen scan-out stream of hack_mem_map.
interface hack_mem_map_if
   import hack_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
);
   logic [DATA_W-1:0] in;
   logic [ADDR_W-1:0] address;
   logic              ld;
   logic [DATA_W-1:0] out;
   logic [DATA_W-1:0] kbd_code;
   logic              kbd_strobe;
   logic              kbd_release;
   logic              scan_en;
   logic              scan_ready;
   logic              scan_valid;
   logic [DATA_W-1:0] scan_data;
   logic              scan_sof;
   logic              scan_eol;

   modport master (
      output in, address, ld, kbd_code, kbd_strobe, kbd_release, scan_en, scan_ready,
      input  out, scan_valid, scan_data, scan_sof, scan_eol
   );

   modport slave (
      input  in, address, ld, kbd_code, kbd_strobe, kbd_release, scan_en, scan_ready,
      output out, scan_valid, scan_data, scan_sof, scan_eol
   );
endinterface

// File: rtl/hack_scr_scan.sv
// Screen scan-out engine: walks the frame buffer and streams words over valid/ready.
module hack_scr_scan
   import hack_mem_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned SCR_AW     = DEF_SCR_AW,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scan_en,
   input  logic              scan_ready,
   output logic [SCR_AW-1:0] rd_addr_c,
   input  logic [DATA_W-1:0] rd_data,
   output logic              scan_valid,
   output logic [DATA_W-1:0] scan_data,
   output logic              scan_sof,
   output logic              scan_eol
);
   localparam logic [SCR_AW-1:0] LINE_MASK = SCR_AW'(LINE_WORDS - 1);

   scan_state_e       state, state_n;
   logic [SCR_AW-1:0] ptr, ptr_n;
   logic              valid_n, sof_n, eol_n;
   logic [DATA_W-1:0] data_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SCAN_IDLE;
         ptr        <= '0;
         scan_valid <= 1'b0;
         scan_data  <= '0;
         scan_sof   <= 1'b0;
         scan_eol   <= 1'b0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         scan_valid <= valid_n;
         scan_data  <= data_n;
         scan_sof   <= sof_n;
         scan_eol   <= eol_n;
      end
   end

   // Fetch reads the screen combinationally; the register captures pre-write data.
   assign rd_addr_c = ptr;

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      valid_n = scan_valid;
      data_n  = scan_data;
      sof_n   = scan_sof;
      eol_n   = scan_eol;
      case (state)
         SCAN_IDLE: begin
            ptr_n   = '0;
            valid_n = 1'b0;
            if (scan_en) state_n = SCAN_RUN;
         end
         SCAN_RUN: begin
            if (!scan_valid || scan_ready) begin
               if (scan_en) begin
                  valid_n = 1'b1;
                  data_n  = rd_data;
                  sof_n   = (ptr == '0);
                  eol_n   = ((ptr & LINE_MASK) == LINE_MASK);
                  ptr_n   = ptr + SCR_AW'(1);
               end else begin
                  valid_n = 1'b0;
                  ptr_n   = '0;
                  state_n = SCAN_IDLE;
               end
            end
         end
         default: state_n = SCAN_IDLE;
      endcase
   end

endmodule

// File: rtl/hack_mem_map.sv
// Hack data memory: RAM, screen buffer and KBD register behind one CPU port.
// Define HACK_MEM_SCAN_EN to build the screen scan-out engine.
module hack_mem_map
   import hack_mem_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned RAM_AW     = DEF_RAM_AW,
   parameter int unsigned SCR_AW     = DEF_SCR_AW,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic           clk,
   input  logic           rst_n,
   hack_mem_map_if.slave  bus
);
   localparam int unsigned    AW1       = ADDR_W + 1;
   localparam int unsigned    RAM_DEPTH = 32'd1 << RAM_AW;
   localparam int unsigned    SCR_DEPTH = 32'd1 << SCR_AW;
   localparam logic [AW1-1:0] RAM_END   = AW1'(RAM_DEPTH);
   localparam logic [AW1-1:0] KBD_ADDR  = AW1'(kbd_addr(RAM_AW, SCR_AW));

   logic [DATA_W-1:0] ram [RAM_DEPTH];
   logic [DATA_W-1:0] scr [SCR_DEPTH];
   logic [DATA_W-1:0] kbd;
   logic [AW1-1:0]    addr_ext;
   logic [RAM_AW-1:0] ram_idx;
   logic [SCR_AW-1:0] scr_idx;
   region_e           region;

   assign addr_ext = {1'b0, bus.address};
   assign ram_idx  = RAM_AW'(bus.address);
   assign scr_idx  = SCR_AW'(addr_ext - RAM_END);

   always_comb begin
      region = REG_NONE;
      if (addr_ext < RAM_END)       region = REG_RAM;
      else if (addr_ext < KBD_ADDR) region = REG_SCR;
      else if (addr_ext == KBD_ADDR) region = REG_KBD;
   end

   always_comb begin
      bus.out = '0;
      case (region)
         REG_RAM: bus.out = ram[ram_idx];
         REG_SCR: bus.out = scr[scr_idx];
         REG_KBD: bus.out = kbd;
         default: bus.out = '0;
      endcase
   end

   // Arrays carry no reset; KBD and unmapped writes are dropped.
   always_ff @(posedge clk) begin
      if (bus.ld && region == REG_RAM) ram[ram_idx] <= bus.in;
      if (bus.ld && region == REG_SCR) scr[scr_idx] <= bus.in;
   end

   // Key press takes priority over release in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               kbd <= '0;
      else if (bus.kbd_strobe)  kbd <= bus.kbd_code;
      else if (bus.kbd_release) kbd <= '0;
   end

`ifdef HACK_MEM_SCAN_EN
   logic [SCR_AW-1:0] scan_addr_c;
   logic [DATA_W-1:0] scan_rd;

   assign scan_rd = scr[scan_addr_c];

   hack_scr_scan #(
      .DATA_W     (DATA_W),
      .SCR_AW     (SCR_AW),
      .LINE_WORDS (LINE_WORDS)
   ) u_scan (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_en    (bus.scan_en),
      .scan_ready (bus.scan_ready),
      .rd_addr_c  (scan_addr_c),
      .rd_data    (scan_rd),
      .scan_valid (bus.scan_valid),
      .scan_data  (bus.scan_data),
      .scan_sof   (bus.scan_sof),
      .scan_eol   (bus.scan_eol)
   );
`else
   logic unused_scan;

   assign bus.scan_valid = 1'b0;
   assign bus.scan_data  = '0;
   assign bus.scan_sof   = 1'b0;
   assign bus.scan_eol   = 1'b0;
   assign unused_scan    = ^{bus.scan_en, bus.scan_ready, LINE_WORDS};
`endif

endmodule

// File: tb/tb_hack_mem_map.sv
// Directed bench for hack_mem_map; scan-out steps run when HACK_MEM_SCAN_EN is defined.
module tb_hack_mem_map;
   localparam int unsigned S = 8192;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   hack_mem_map_if #(.DATA_W(16), .ADDR_W(15)) bus ();

   hack_mem_map dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [14:0] a, input logic [15:0] d);
      bus.address = a;
      bus.in      = d;
      bus.ld      = 1'b1;
      tick();
      bus.ld      = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [14:0] a, input logic [15:0] exp);
      bus.address = a;
      #1;
      chk(tag, 32'(bus.out), 32'(exp));
   endtask

   function automatic logic [31:0] beat_obs();
      return 32'({bus.scan_valid, bus.scan_sof, bus.scan_eol, bus.scan_data});
   endfunction

   function automatic logic [31:0] beat(input logic v, input logic s, input logic e, input logic [15:0] d);
      return 32'({v, s, e, d});
   endfunction

   initial begin
      errors          = 0;
      checks          = 0;
      rst_n           = 1'b0;
      bus.in          = '0;
      bus.address     = 15'h6000;
      bus.ld          = 1'b0;
      bus.kbd_code    = '0;
      bus.kbd_strobe  = 1'b0;
      bus.kbd_release = 1'b0;
      bus.scan_en     = 1'b0;
      bus.scan_ready  = 1'b0;
      #3;
      chk("reset_scan", beat_obs(), 32'h0);
      chk("reset_kbd", 32'(bus.out), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // CPU map
      wr(15'h0005, 16'h1234);
      wr(15'h4000, 16'hBEEF);
      rd_chk("ram_rd", 15'h0005, 16'h1234);
      rd_chk("scr_rd", 15'h4000, 16'hBEEF);
      rd_chk("unmapped_rd", 15'h6001, 16'h0000);
      wr(15'h6001, 16'h5555);
      rd_chk("unmapped_wr", 15'h6001, 16'h0000);
      wr(15'h3FFF, 16'hA5A5);
      wr(15'h5FFF, 16'h5A5A);
      rd_chk("ram_top", 15'h3FFF, 16'hA5A5);
      rd_chk("scr_top", 15'h5FFF, 16'h5A5A);
      rd_chk("ram_keep", 15'h0005, 16'h1234);

      // Keyboard register
      bus.kbd_code   = 16'h0041;
      bus.kbd_strobe = 1'b1;
      tick();
      bus.kbd_strobe = 1'b0;
      rd_chk("kbd_strobe", 15'h6000, 16'h0041);
      wr(15'h6000, 16'hFFFF);
      rd_chk("kbd_ro", 15'h6000, 16'h0041);
      bus.kbd_code    = 16'h0042;
      bus.kbd_strobe  = 1'b1;
      bus.kbd_release = 1'b1;
      tick();
      bus.kbd_strobe  = 1'b0;
      rd_chk("kbd_both", 15'h6000, 16'h0042);
      tick();
      rd_chk("kbd_hold", 15'h6000, 16'h0000);
      bus.kbd_release = 1'b0;
      bus.kbd_code    = 16'h0043;
      bus.kbd_strobe  = 1'b1;
      tick();
      bus.kbd_strobe  = 1'b0;
      bus.kbd_release = 1'b1;
      tick();
      bus.kbd_release = 1'b0;
      rd_chk("kbd_release", 15'h6000, 16'h0000);

`ifdef HACK_MEM_SCAN_EN
      for (int i = 0; i < int'(S); i++) wr(15'(32'h4000 + i), 16'(i));
      rd_chk("fill_last", 15'h5FFF, 16'h1FFF);

      bus.scan_en    = 1'b1;
      bus.scan_ready = 1'b1;
      tick();
      chk("scan_latency", 32'(bus.scan_valid), 32'h0);
      tick();
      for (int k = 0; k < int'(S) + 48; k++) begin
         int          idx;
         logic [15:0] exp_d;
         idx   = k % int'(S);
         exp_d = (k >= int'(S) && idx == 3) ? 16'hAAAA : 16'(idx);
         chk($sformatf("word%0d", k), beat_obs(),
             beat(1'b1, idx == 0, (idx % 32) == 31, exp_d));
         if (k == 2) begin
            bus.address = 15'h4003;
            bus.in      = 16'hAAAA;
            bus.ld      = 1'b1;
         end
         if (k == 10) begin
            bus.scan_ready = 1'b0;
            repeat (5) begin
               tick();
               chk("stall_hold", beat_obs(), beat(1'b1, 1'b0, 1'b0, 16'd10));
            end
            bus.scan_ready = 1'b1;
         end
         tick();
         if (k == 2) bus.ld = 1'b0;
      end
      rd_chk("collide_commit", 15'h4003, 16'hAAAA);

      // Disable with a pending word, then restart at frame start
      bus.scan_en    = 1'b0;
      bus.scan_ready = 1'b0;
      tick();
      chk("dis_pending", beat_obs(), beat(1'b1, 1'b0, 1'b0, 16'd48));
      bus.scan_ready = 1'b1;
      tick();
      chk("dis_drop", 32'(bus.scan_valid), 32'h0);
      bus.scan_en = 1'b1;
      tick();
      chk("restart_lat", 32'(bus.scan_valid), 32'h0);
      tick();
      chk("restart_w0", beat_obs(), beat(1'b1, 1'b1, 1'b0, 16'd0));
      tick();
      chk("restart_w1", beat_obs(), beat(1'b1, 1'b0, 1'b0, 16'd1));
`else
      bus.scan_en    = 1'b1;
      bus.scan_ready = 1'b1;
      repeat (3) begin
         tick();
         chk("scan_tied", beat_obs(), 32'h0);
      end
`endif

      // Asynchronous reset mid-frame
      bus.kbd_code   = 16'h0077;
      bus.kbd_strobe = 1'b1;
      tick();
      bus.kbd_strobe = 1'b0;
      rd_chk("kbd_pre_rst", 15'h6000, 16'h0077);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_scan", beat_obs(), 32'h0);
      chk("rst_kbd", 32'(bus.out), 32'h0);
      tick();
      rst_n = 1'b1;
`ifdef HACK_MEM_SCAN_EN
      tick();
      chk("rst_lat", 32'(bus.scan_valid), 32'h0);
      tick();
      chk("rst_w0", beat_obs(), beat(1'b1, 1'b1, 1'b0, 16'd0));
`else
      tick();
      chk("rst_tied", beat_obs(), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hack_mem_map.md
# hack_mem_map

Parametrised Hack data-memory map combining RAM, screen buffer and keyboard register behind one CPU port. It also contains a screen scan-out engine that streams frame-buffer words to a display sink over a valid/ready handshake. The block sits between the Hack CPU data port and the display/keyboard front end. It generalises the fixed 16K/8K/KBD memory to configurable widths and depths and adds a second, registered read path for the screen.

## Interface
Parameters:
- DATA_W, 16, word width
- ADDR_W, 15, CPU address width
- RAM_AW, 14, RAM address width; RAM depth is 2^RAM_AW
- SCR_AW, 13, screen address width; screen depth is 2^SCR_AW
- LINE_WORDS, 32, words per display line; must be a power of two dividing 2^SCR_AW

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in  in  DATA_W  CPU write data
- address  in  ADDR_W  CPU address
- ld  in  1  CPU write enable
- out  out  DATA_W  CPU read data (combinational)
- kbd_code  in  DATA_W  key code from keyboard front end
- kbd_strobe  in  1  key-press pulse
- kbd_release  in  1  key-release pulse
- scan_en  in  1  scan-out enable (level)
- scan_ready  in  1  sink accepts a word
- scan_valid  out  1  scan_data is valid
- scan_data  out  DATA_W  screen word
- scan_sof  out  1  word is screen address 0 (start of frame)
- scan_eol  out  1  word is the last word of a line

## Operation
- Address map, with R = 2^RAM_AW and S = 2^SCR_AW:
  - [0, R) → RAM
  - [R, R+S) → screen, index address−R
  - R+S → KBD
  - all other addresses → unmapped
- Defaults give RAM 0x0000–0x3FFF, screen 0x4000–0x5FFF, KBD 0x6000.
- Unmapped reads return 0. Unmapped writes are ignored.
- Writes with ld=1 go to RAM or screen at the rising edge. Writes to KBD are ignored; KBD is read-only to the CPU.
- out is purely combinational from address and memory contents.
- KBD register:
  - kbd_strobe loads kbd_code.
  - kbd_release clears it to 0.
  - If both pulses arrive in the same cycle, strobe wins.
- Scan engine states:
  - IDLE: scan_valid=0; pointer ptr=0. Go to RUN when scan_en=1.
  - RUN: whenever scan_valid=0 or scan_ready=1, load scan_data=screen[ptr], set scan_valid=1, scan_sof=(ptr==0), scan_eol=(ptr mod LINE_WORDS == LINE_WORDS−1), then ptr += 1. ptr wraps from S−1 to 0.
  - While scan_valid=1 and scan_ready=0, scan_data, scan_sof and scan_eol hold stable.
  - If scan_en=0 in RUN: no new word is loaded. A pending word stays valid until accepted, then scan_valid drops and the engine returns to IDLE with ptr=0. The next enable restarts at the frame start.
- Memory arrays are not reset; their contents after reset are undefined.

## Timing
- Reset values: scan_valid=0, scan_data=0, scan_sof=0, scan_eol=0, KBD register=0, ptr=0, state=IDLE. out follows address; out at KBD reads 0 after reset.
- CPU read latency is 0 cycles. A CPU write is visible on out the cycle after the edge.
- Scan latency: scan_en rises at edge N; the first word is valid after edge N+1.
- Steady state with scan_ready=1 streams one word per cycle.
- Collision: CPU write and scan fetch at the same screen index in the same cycle → scan gets the old data (read-before-write); the CPU write still commits.
- Reset asserted mid-frame: scan_valid drops immediately (asynchronously); ptr=0.

## Configuration
- HACK_MEM_SCAN_EN defined: scan engine and screen second read port are built.
- HACK_MEM_SCAN_EN undefined: scan_valid, scan_data, scan_sof and scan_eol are tied to 0; scan_en and scan_ready are ignored; screen uses a single port. The CPU map is unchanged.

## Structure
- Shared package hack_mem_pkg holds:
  - region-decode enum (REG_RAM, REG_SCR, REG_KBD, REG_NONE)
  - scan state enum (SCAN_IDLE, SCAN_RUN)
  - default width constants
  - base-address function kbd_addr(RAM_AW, SCR_AW)
- One sub-module: hack_scr_scan (scan FSM, pointer, output registers), instantiated only under HACK_MEM_SCAN_EN.

## Test plan
- Write 0x1234 at 0x0005 and 0xBEEF at 0x4000, then read both → out=0x1234 and 0xBEEF; read 0x6001 → 0; write to 0x6001, then read → 0.
- kbd_strobe with kbd_code=0x0041 → read 0x6000 returns 0x0041. Write 0xFFFF to 0x6000 → still 0x0041. Strobe and release in the same cycle with code 0x0042 → 0x0042. Release alone → 0.
- Fill screen[i]=i, scan_en=1, scan_ready=1 → words 0,1,2… one per cycle; sof only on word 0; eol on words 31, 63, …; after word 8191, word 0 follows with sof.
- Hold scan_ready=0 for 5 cycles mid-line → scan_data, scan_sof and scan_eol stable; no word skipped or duplicated after release.
- CPU writes 0xAAAA to 0x4003 in the same cycle the scan fetches index 3 (old value 0x0003) → streamed word is 0x0003; the next frame streams 0xAAAA.
- Pulse rst_n low mid-frame → outputs zero immediately; after release with scan_en=1, the first word is index 0 with sof=1.
